bp_resolve_queue: RTL and testbench
===================================

# bp_resolve_queue

Fetch-to-execute prediction tracker that closes the loop on the BTB. Each fetched instruction's prediction is recorded at IF and checked against the real outcome when that instruction resolves in EX. On a mismatch the block issues a one-cycle redirect/flush with the correct PC and discards all younger in-flight predictions. It sits beside the BTB: the BTB answers "where next" at IF, and this block answers "was that right" at EX.

## Interface
- DEPTH, 4, in-flight prediction entries; power of 2, ≥2
- CNT_W, 32, width of performance counters

- clk  in  1  clock
- rst  in  1  reset
- if_push  in  1  fetched instruction enters pipeline; record its prediction
- if_pc  in  32  PC of fetched instruction
- if_pred_taken  in  1  BTB hit (predicted redirect)
- if_pred_pc  in  32  BTB predicted target
- full  out  1  queue holds DEPTH entries; fetch must stall
- empty  out  1  queue holds 0 entries
- ex_valid  in  1  oldest in-flight instruction resolves in EX this cycle
- ex_pc  in  32  PC of resolving instruction
- ex_is_ctrl  in  1  resolving instruction is branch or jump
- ex_taken  in  1  control transfer taken (jumps always 1)
- ex_target  in  32  resolved target
- redirect  out  1  mispredict flush pulse
- redirect_pc  out  32  correct next PC, valid while redirect=1
- err  out  1  sticky protocol error
- ctrl_cnt  out  CNT_W  resolved control instructions
- mispred_cnt  out  CNT_W  mispredictions

## Operation
- Entry = {pc, pred_taken, pred_pc}. FIFO order: head = oldest.
- Push is accepted iff if_push && !full && !redirect && !mispredict_now. Otherwise it is dropped silently.
- Pop occurs iff ex_valid && !empty.
- Predicted next = head.pred_taken ? head.pred_pc : head.pc+4.
- Actual next = (ex_is_ctrl && ex_taken) ? ex_target : head.pc+4. Adds are 32-bit and wrap.
- mispredict_now = pop && (predicted next != actual next). This covers a BTB hit on a non-control instruction, a not-taken branch that hit the BTB, and a wrong target.
- On mispredict_now:
  - head and all younger entries are cleared (count←0, pointers←0).
  - Next cycle, redirect=1 and redirect_pc=actual next.
- err is set and held until rst when either:
  - ex_valid while empty (that pop is ignored), or
  - pop with ex_pc != head.pc (the pop and compare still proceed).
- Pointer wrap: DEPTH is a power of 2, so pointers wrap naturally. count is log2(DEPTH)+1 bits.
- Simultaneous push and pop at full: the push is dropped (full is evaluated before the pop). Simultaneous push and pop otherwise: count is unchanged.

## Timing
- full and empty are combinational from registered count and valid in the same cycle.
- redirect has 1-cycle latency from the mispredicting ex_valid. It is a single-cycle pulse; back-to-back pulses cannot occur because the queue is empty after a flush.
- The push cycle coincident with redirect is dropped, because that fetch is wrong-path.
- A pushed entry is poppable from the next cycle.
- Reset values: full=0, empty=1, redirect=0, redirect_pc=0, err=0, counters=0, queue empty.
- Reset mid-flight discards all entries, and any pending redirect is cancelled.

## Configuration
- BP_PERF_CNT_EN defined:
  - ctrl_cnt increments on each pop with ex_is_ctrl.
  - mispred_cnt increments on each mispredict_now.
  - Both saturate at all-ones and clear on rst.
- BP_PERF_CNT_EN undefined: no counter registers exist, and ctrl_cnt and mispred_cnt are tied to 0.

## Structure
- Shared package bp_pkg holds:
  - typedef bp_entry_t {pc, pred_taken, pred_pc}
  - localparam PC_STEP = 4
  - the next-PC selection function, shared with fetch
- Sub-module bp_pred_fifo provides storage, pointers, count, full/empty, and a synchronous clear. The compare, redirect and counter logic live in the top.

## Test plan
- Push 3 entries with no BTB hit at PCs 0x100/0x104/0x108, then pop all 3 with ex_is_ctrl=0 → no redirect, empty=1, err=0.
- Push PC 0x200 with pred_taken=1 and pred_pc=0x300; resolve as taken to 0x300 → no redirect. With BP_PERF_CNT_EN: ctrl_cnt=1, mispred_cnt=0.
- Push 0x200 (not predicted) plus 2 younger entries; resolve 0x200 as taken to 0x400 → redirect=1 the next cycle with redirect_pc=0x400, queue empty, a push in the redirect cycle is dropped, mispred_cnt=1.
- Fill DEPTH=4 entries → full=1. A push together with a pop in the same cycle drops the push, leaving count=3 the next cycle.
- Push PC 0x500 with pred_taken=1; resolve as ex_is_ctrl=0 → redirect_pc=0x504.
- ex_valid while empty → err=1, held until rst. Separately, pop with ex_pc=0x10 against head.pc=0x14 → err=1.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared types and helpers for the BTB prediction-resolve path.
// The next-PC selection function is also used by fetch.
package bp_pkg;

  localparam logic [31:0] PC_STEP = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic        pred_taken;
    logic [31:0] pred_pc;
  } bp_entry_t;

  function automatic logic [31:0] bp_next_pc(input logic        taken,
                                             input logic [31:0] target,
                                             input logic [31:0] pc);
    return taken ? target : pc + PC_STEP;
  endfunction

endpackage

// File: rtl/bp_pred_fifo.sv
// In-flight prediction storage: circular FIFO with synchronous clear.
// Callers must gate push with !full and pop with !empty.
module bp_pred_fifo
  import bp_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr_i,
  input  logic                     push_i,
  input  bp_entry_t                wdata_i,
  input  logic                     pop_i,
  output bp_entry_t                head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q,  count_d;
  bp_entry_t     mem_q [DEPTH];

  always_comb begin
    count_d = count_q;
    if (push_i && !pop_i)      count_d = count_q + 1'b1;
    else if (!push_i && pop_i) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/bp_resolve_queue.sv
// Records BTB predictions at IF and checks them at EX; issues a one-cycle
// redirect on mispredict. Define BP_PERF_CNT_EN to build the perf counters.
module bp_resolve_queue
  import bp_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_push,
  input  logic [31:0]      if_pc,
  input  logic             if_pred_taken,
  input  logic [31:0]      if_pred_pc,
  output logic             full,
  output logic             empty,
  input  logic             ex_valid,
  input  logic [31:0]      ex_pc,
  input  logic             ex_is_ctrl,
  input  logic             ex_taken,
  input  logic [31:0]      ex_target,
  output logic             redirect,
  output logic [31:0]      redirect_pc,
  output logic             err,
  output logic [CNT_W-1:0] ctrl_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);

  bp_entry_t               head, wdata;
  logic                    pop, push_ok, mispredict_now;
  logic [31:0]             pred_next, act_next;
  logic [$clog2(DEPTH):0]  count_unused;
  logic                    redirect_q;
  logic [31:0]             redirect_pc_q;
  logic                    err_q;

  assign pop       = ex_valid && !empty;
  assign pred_next = bp_next_pc(head.pred_taken, head.pred_pc, head.pc);
  assign act_next  = bp_next_pc(ex_is_ctrl && ex_taken, ex_target, head.pc);
  assign mispredict_now = pop && (pred_next != act_next);
  // Fetch in the mispredict or redirect cycle is wrong-path and is dropped.
  assign push_ok   = if_push && !full && !redirect_q && !mispredict_now;
  assign wdata     = '{pc: if_pc, pred_taken: if_pred_taken, pred_pc: if_pred_pc};

  bp_pred_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (mispredict_now),
    .push_i  (push_ok),
    .wdata_i (wdata),
    .pop_i   (pop),
    .head_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count_unused)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
      err_q         <= 1'b0;
    end else begin
      redirect_q <= mispredict_now;
      if (mispredict_now) redirect_pc_q <= act_next;
      if ((ex_valid && empty) || (pop && ex_pc != head.pc)) err_q <= 1'b1;
    end
  end

  assign redirect    = redirect_q;
  assign redirect_pc = redirect_pc_q;
  assign err         = err_q;

`ifdef BP_PERF_CNT_EN
  logic [CNT_W-1:0] ctrl_cnt_q, mispred_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_cnt_q    <= '0;
      mispred_cnt_q <= '0;
    end else begin
      if (pop && ex_is_ctrl && ctrl_cnt_q != '1) ctrl_cnt_q <= ctrl_cnt_q + 1'b1;
      if (mispredict_now && mispred_cnt_q != '1) mispred_cnt_q <= mispred_cnt_q + 1'b1;
    end
  end

  assign ctrl_cnt    = ctrl_cnt_q;
  assign mispred_cnt = mispred_cnt_q;
`else
  assign ctrl_cnt    = '0;
  assign mispred_cnt = '0;
`endif

endmodule

// File: tb/tb_bp_resolve_queue.sv
// Directed self-checking bench for bp_resolve_queue (DEPTH=4).
module tb_bp_resolve_queue;

`ifdef BP_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        if_push, if_pred_taken;
  logic [31:0] if_pc, if_pred_pc;
  logic        full, empty;
  logic        ex_valid, ex_is_ctrl, ex_taken;
  logic [31:0] ex_pc, ex_target;
  logic        redirect, err;
  logic [31:0] redirect_pc;
  logic [31:0] ctrl_cnt, mispred_cnt;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  bp_resolve_queue #(.DEPTH(4), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .if_push(if_push), .if_pc(if_pc), .if_pred_taken(if_pred_taken), .if_pred_pc(if_pred_pc),
    .full(full), .empty(empty),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_is_ctrl(ex_is_ctrl), .ex_taken(ex_taken),
    .ex_target(ex_target),
    .redirect(redirect), .redirect_pc(redirect_pc), .err(err),
    .ctrl_cnt(ctrl_cnt), .mispred_cnt(mispred_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    if_push = 0; if_pc = '0; if_pred_taken = 0; if_pred_pc = '0;
    ex_valid = 0; ex_pc = '0; ex_is_ctrl = 0; ex_taken = 0; ex_target = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic push(input logic [31:0] pc, input logic pt, input logic [31:0] ppc);
    if_push = 1; if_pc = pc; if_pred_taken = pt; if_pred_pc = ppc;
    tick();
    if_push = 0;
  endtask

  task automatic pop(input logic [31:0] pc, input logic ctrl, input logic tk, input logic [31:0] tgt);
    ex_valid = 1; ex_pc = pc; ex_is_ctrl = ctrl; ex_taken = tk; ex_target = tgt;
    tick();
    ex_valid = 0;
  endtask

  function automatic logic [31:0] perf(input int unsigned n);
    return PERF ? n : 0;
  endfunction

  initial begin
    clear_inputs();
    do_reset();
    check("rst_full", full, 0);
    check("rst_empty", empty, 1);
    check("rst_redirect", redirect, 0);
    check("rst_redirect_pc", redirect_pc, 0);
    check("rst_err", err, 0);
    check("rst_ctrl_cnt", ctrl_cnt, 0);
    check("rst_mispred_cnt", mispred_cnt, 0);

    // Sequential, no BTB hits
    push(32'h100, 0, 0); push(32'h104, 0, 0); push(32'h108, 0, 0);
    check("seq_empty_after_push", empty, 0);
    pop(32'h100, 0, 0, 0); check("seq_redir0", redirect, 0);
    pop(32'h104, 0, 0, 0); check("seq_redir1", redirect, 0);
    pop(32'h108, 0, 0, 0); check("seq_redir2", redirect, 0);
    check("seq_empty", empty, 1);
    check("seq_err", err, 0);

    // Correctly predicted taken branch
    push(32'h200, 1, 32'h300);
    pop(32'h200, 1, 1, 32'h300);
    check("hit_redirect", redirect, 0);
    check("hit_ctrl_cnt", ctrl_cnt, perf(1));
    check("hit_mispred_cnt", mispred_cnt, perf(0));

    // Unpredicted taken branch flushes younger entries
    push(32'h200, 0, 0); push(32'h204, 0, 0); push(32'h208, 0, 0);
    pop(32'h200, 1, 1, 32'h400);
    check("mp_redirect", redirect, 1);
    check("mp_redirect_pc", redirect_pc, 32'h400);
    check("mp_empty", empty, 1);
    push(32'h600, 0, 0);
    check("mp_redirect_pulse", redirect, 0);
    check("mp_push_dropped", empty, 1);
    check("mp_ctrl_cnt", ctrl_cnt, perf(2));
    check("mp_mispred_cnt", mispred_cnt, perf(1));

    // Full, and push+pop at full drops the push
    push(32'h700, 0, 0); push(32'h704, 0, 0); push(32'h708, 0, 0);
    check("fill3_full", full, 0);
    push(32'h70C, 0, 0);
    check("fill4_full", full, 1);
    if_push = 1; if_pc = 32'h710; if_pred_taken = 0; if_pred_pc = '0;
    pop(32'h700, 0, 0, 0);
    if_push = 0;
    check("pp_full", full, 0);
    check("pp_redirect", redirect, 0);
    pop(32'h704, 0, 0, 0);
    pop(32'h708, 0, 0, 0);
    check("pp_not_empty_at1", empty, 0);
    pop(32'h70C, 0, 0, 0);
    check("pp_count3_drained", empty, 1);
    check("pp_err", err, 0);

    // BTB hit on non-control instruction
    push(32'h500, 1, 32'h900);
    pop(32'h500, 0, 0, 0);
    check("nc_redirect", redirect, 1);
    check("nc_redirect_pc", redirect_pc, 32'h504);
    check("nc_ctrl_cnt", ctrl_cnt, perf(2));
    check("nc_mispred_cnt", mispred_cnt, perf(2));
    tick();
    check("nc_err", err, 0);

    // ex_valid while empty -> sticky err
    pop(32'h0, 0, 0, 0);
    check("emp_err", err, 1);
    check("emp_redirect", redirect, 0);
    tick(); tick();
    check("emp_err_held", err, 1);
    do_reset();
    check("emp_err_cleared", err, 0);
    check("rst2_ctrl_cnt", ctrl_cnt, 0);

    // PC mismatch at pop
    push(32'h14, 0, 0);
    pop(32'h10, 0, 0, 0);
    check("pcmm_err", err, 1);
    check("pcmm_redirect", redirect, 0);
    check("pcmm_empty", empty, 1);

    // Reset in the mispredict cycle cancels the redirect
    do_reset();
    push(32'h800, 0, 0); push(32'h804, 0, 0);
    rst = 1;
    pop(32'h800, 1, 1, 32'hA00);
    rst = 0;
    check("rstmid_redirect", redirect, 0);
    check("rstmid_redirect_pc", redirect_pc, 0);
    check("rstmid_empty", empty, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
